mapa_grid_ram: RTL and testbench

- Parametrised tile-map memory for the snake game.
- Stores one CELL_BITS code per grid cell and serves three ports: a VGA renderer read port with colour decode, an update-logic read port and an update-logic write port.
- A built-in clear engine sweeps the whole grid after reset or on request. It writes empty cells, plus optional obstacle cells on the border, so the game can restart without reconfiguring the FPGA.
- Sits between the game-logic FSM (update ports) and the VGA renderer (render port).

---
 rtl/mapa_grid_ram_if.sv | 39 +++
 rtl/mapa_grid_ram.sv | 136 +++++++++++++
 tb/tb_mapa_grid_ram.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mapa_grid_ram_if.sv
// Bus bundle between the snake game logic / VGA renderer (master) and the tile-map memory (slave).
// Strobes are single-cycle: a request is taken on the edge where its enable is high; update_rvalid
// answers an accepted read exactly one cycle later, and nothing is accepted while busy is high.
interface mapa_grid_ram_if #(
  parameter int CELL_BITS  = 2,
  parameter int COLOR_BITS = 2
);
  logic                  clear_req;
  logic                  busy;
  logic                  vga_read;
  logic [9:0]            renderer_rx;
  logic [9:0]            renderer_ry;
  logic [COLOR_BITS-1:0] mapa_R;
  logic [COLOR_BITS-1:0] mapa_G;
  logic [COLOR_BITS-1:0] mapa_B;
  logic                  update_renable;
  logic [9:0]            update_rx;
  logic [9:0]            update_ry;
  logic [CELL_BITS-1:0]  update_rdata;
  logic                  update_rvalid;
  logic                  update_wenable;
  logic [9:0]            update_wx;
  logic [9:0]            update_wy;
  logic [CELL_BITS-1:0]  update_wdata;

  modport master (
    output clear_req, vga_read, renderer_rx, renderer_ry,
    output update_renable, update_rx, update_ry,
    output update_wenable, update_wx, update_wy, update_wdata,
    input  busy, mapa_R, mapa_G, mapa_B, update_rdata, update_rvalid
  );

  modport slave (
    input  clear_req, vga_read, renderer_rx, renderer_ry,
    input  update_renable, update_rx, update_ry,
    input  update_wenable, update_wx, update_wy, update_wdata,
    output busy, mapa_R, mapa_G, mapa_B, update_rdata, update_rvalid
  );
endinterface

// File: rtl/mapa_grid_ram.sv
// Snake game tile map: [y][x] cell store with renderer colour port, logic read/write ports
// and a self-clearing sweep that runs after reset or on clear_req.
module mapa_grid_ram #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int CELL_BITS   = 2,
  parameter int COLOR_BITS  = 2,
  parameter int BORDER      = 1
) (
  input  logic            clk,
  input  logic            reset,
  mapa_grid_ram_if.slave  bus,
  output logic            dbg_state
);

  localparam int XW = (MAPA_WIDTH  > 1) ? $clog2(MAPA_WIDTH)  : 1;
  localparam int YW = (MAPA_HEIGHT > 1) ? $clog2(MAPA_HEIGHT) : 1;
  localparam logic [CELL_BITS-1:0] OBSTACLE = '1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [XW-1:0]        sx_q;
  logic [YW-1:0]        sy_q;
  logic                 busy;
  logic                 sweep_last;
  logic                 sweep_border;
  logic [CELL_BITS-1:0] sweep_data;
  logic                 r_in, u_in, w_in;
  logic [CELL_BITS-1:0] cell_q;
  logic [CELL_BITS-1:0] rdata_q;
  logic                 rvalid_q;
  logic [COLOR_BITS-1:0] col_r, col_g, col_b;

  logic [CELL_BITS-1:0] mem [MAPA_HEIGHT][MAPA_WIDTH];

  assign busy      = (state_q == S_CLEAR);
  assign dbg_state = state_q;

  assign sweep_last   = (sx_q == XW'(MAPA_WIDTH - 1)) && (sy_q == YW'(MAPA_HEIGHT - 1));
  assign sweep_border = (BORDER != 0) &&
                        ((sx_q == '0) || (sx_q == XW'(MAPA_WIDTH - 1)) ||
                         (sy_q == '0) || (sy_q == YW'(MAPA_HEIGHT - 1)));
  assign sweep_data   = sweep_border ? OBSTACLE : '0;

  assign r_in = (bus.renderer_rx < 10'(MAPA_WIDTH)) && (bus.renderer_ry < 10'(MAPA_HEIGHT));
  assign u_in = (bus.update_rx   < 10'(MAPA_WIDTH)) && (bus.update_ry   < 10'(MAPA_HEIGHT));
  assign w_in = (bus.update_wx   < 10'(MAPA_WIDTH)) && (bus.update_wy   < 10'(MAPA_HEIGHT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.clear_req) state_d = S_CLEAR;
      S_CLEAR: if (sweep_last)    state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // Sweep index parks at 0 outside CLEAR so every sweep starts from (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      if (busy && !sweep_last) begin
        if (sx_q == XW'(MAPA_WIDTH - 1)) begin
          sx_q <= '0;
          sy_q <= sy_q + 1'b1;
        end else begin
          sx_q <= sx_q + 1'b1;
        end
      end else begin
        sx_q <= '0;
        sy_q <= '0;
      end
    end
  end

  // The sweep owns the write port; game writes are dropped until it finishes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy)
        mem[sy_q][sx_q] <= sweep_data;
      else if (bus.update_wenable && w_in)
        mem[bus.update_wy[YW-1:0]][bus.update_wx[XW-1:0]] <= bus.update_wdata;
    end
  end

  // Both read ports are registered reads of the old contents (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (bus.vga_read) begin
        if (busy || !r_in) cell_q <= '0;
        else               cell_q <= mem[bus.renderer_ry[YW-1:0]][bus.renderer_rx[XW-1:0]];
      end
      rvalid_q <= bus.update_renable && !busy;
      if (bus.update_renable && !busy) begin
        if (u_in) rdata_q <= mem[bus.update_ry[YW-1:0]][bus.update_rx[XW-1:0]];
        else      rdata_q <= '0;
      end
    end
  end

  always_comb begin
    col_r = '0;
    col_g = '0;
    col_b = '0;
    if (cell_q == '0) begin
      col_r = '0;
    end else if (cell_q == CELL_BITS'(1)) begin
      col_g = '1;
    end else if (cell_q == CELL_BITS'(2)) begin
      col_r = '1;
    end else if (cell_q == OBSTACLE) begin
      col_b = '1;
    end else begin
      col_r = '1;
      col_g = '1;
      col_b = '1;
    end
  end

  assign bus.busy          = busy;
  assign bus.mapa_R        = col_r;
  assign bus.mapa_G        = col_g;
  assign bus.mapa_B        = col_b;
  assign bus.update_rdata  = rdata_q;
  assign bus.update_rvalid = rvalid_q;

endmodule

// File: tb/tb_mapa_grid_ram.sv
// Directed bench for mapa_grid_ram: update reads are scoreboarded through exp_q by a monitor,
// renderer colours, busy timing and the BORDER=0 build are checked inline.
module tb_mapa_grid_ram;

  logic clk;
  logic reset;
  logic dbg_state;
  logic dbg_state2;

  mapa_grid_ram_if #(.CELL_BITS(2), .COLOR_BITS(2)) bus ();
  mapa_grid_ram_if #(.CELL_BITS(2), .COLOR_BITS(2)) bus2 ();

  mapa_grid_ram #(.MAPA_WIDTH(40), .MAPA_HEIGHT(30), .CELL_BITS(2), .COLOR_BITS(2), .BORDER(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  mapa_grid_ram #(.MAPA_WIDTH(40), .MAPA_HEIGHT(30), .CELL_BITS(2), .COLOR_BITS(2), .BORDER(0)) dut_nb (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus2),
    .dbg_state (dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rgb(input string name, input int r, input int g, input int b);
    check({name, "_R"}, int'(bus.mapa_R), r);
    check({name, "_G"}, int'(bus.mapa_G), g);
    check({name, "_B"}, int'(bus.mapa_B), b);
  endtask

  // Monitor: every rvalid pops one expected cell value.
  always @(negedge clk) begin
    if (!reset && bus.update_rvalid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL upd_rvalid: unexpected rvalid with rdata %0d, expected none", bus.update_rdata);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (bus.update_rdata !== e) begin
          n_errors++;
          $display("FAIL upd_rdata: got %0d expected %0d", bus.update_rdata, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic upd_read(input int x, input int y, input logic [1:0] e);
    @(negedge clk);
    bus.update_renable = 1'b1;
    bus.update_rx      = 10'(x);
    bus.update_ry      = 10'(y);
    exp_q.push_back(e);
    @(negedge clk);
    bus.update_renable = 1'b0;
  endtask

  task automatic upd_write(input int x, input int y, input logic [1:0] d);
    @(negedge clk);
    bus.update_wenable = 1'b1;
    bus.update_wx      = 10'(x);
    bus.update_wy      = 10'(y);
    bus.update_wdata   = d;
    @(negedge clk);
    bus.update_wenable = 1'b0;
  endtask

  task automatic render_read(input string name, input int x, input int y,
                             input int r, input int g, input int b);
    @(negedge clk);
    bus.vga_read    = 1'b1;
    bus.renderer_rx = 10'(x);
    bus.renderer_ry = 10'(y);
    @(negedge clk);
    bus.vga_read = 1'b0;
    check_rgb(name, r, g, b);
  endtask

  task automatic nb_read(input string name, input int x, input int y, input int e);
    @(negedge clk);
    bus2.update_renable = 1'b1;
    bus2.update_rx      = 10'(x);
    bus2.update_ry      = 10'(y);
    @(negedge clk);
    bus2.update_renable = 1'b0;
    check({name, "_rvalid"}, int'(bus2.update_rvalid), 1);
    check({name, "_rdata"}, int'(bus2.update_rdata), e);
  endtask

  // Counts busy samples from the current negedge onward, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 5000) $display("FAIL busy_timeout: busy still high after %0d cycles, expected 1200", cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset = 1'b1;
    bus.clear_req = 1'b0;  bus.vga_read = 1'b0;
    bus.renderer_rx = '0;  bus.renderer_ry = '0;
    bus.update_renable = 1'b0; bus.update_rx = '0; bus.update_ry = '0;
    bus.update_wenable = 1'b0; bus.update_wx = '0; bus.update_wy = '0; bus.update_wdata = '0;
    bus2.clear_req = 1'b0; bus2.vga_read = 1'b0;
    bus2.renderer_rx = '0; bus2.renderer_ry = '0;
    bus2.update_renable = 1'b0; bus2.update_rx = '0; bus2.update_ry = '0;
    bus2.update_wenable = 1'b0; bus2.update_wx = '0; bus2.update_wy = '0; bus2.update_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_rvalid", int'(bus.update_rvalid), 0);
    check("rst_rdata", int'(bus.update_rdata), 0);
    check_rgb("rst_colour", 0, 0, 0);

    reset = 1'b0;
    count_busy(cnt);
    check("init_busy_cycles", cnt, 1200);

    upd_read(0, 0, 2'd3);
    upd_read(5, 5, 2'd0);
    upd_read(39, 29, 2'd3);
    nb_read("noborder_00", 0, 0, 0);

    upd_write(10, 7, 2'd2);
    render_read("fruit", 10, 7, 3, 0, 0);
    upd_write(11, 7, 2'd1);
    render_read("snake", 11, 7, 0, 3, 0);
    render_read("obstacle", 0, 0, 0, 0, 3);
    @(negedge clk);
    check_rgb("hold", 0, 0, 3);

    // Same-cycle read and write of (4,4): old value first.
    @(negedge clk);
    bus.update_wenable = 1'b1; bus.update_wx = 10'd4; bus.update_wy = 10'd4; bus.update_wdata = 2'd1;
    bus.update_renable = 1'b1; bus.update_rx = 10'd4; bus.update_ry = 10'd4;
    exp_q.push_back(2'd0);
    @(negedge clk);
    bus.update_wenable = 1'b0;
    bus.update_renable = 1'b0;
    upd_read(4, 4, 2'd1);

    upd_write(40, 0, 2'd1);
    upd_read(39, 0, 2'd3);
    upd_read(0, 1, 2'd3);
    upd_read(0, 30, 2'd0);
    render_read("oor_render", 50, 50, 0, 0, 0);

    // clear_req from IDLE, with reads and a second clear_req during the sweep.
    upd_write(3, 3, 2'd2);
    render_read("pre_clear", 3, 3, 3, 0, 0);
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    check("clear_busy", int'(bus.busy), 1);
    cnt = 0;
    while (bus.busy && cnt < 5000) begin
      cnt++;
      case (cnt)
        5: begin
          bus.vga_read = 1'b1; bus.renderer_rx = 10'd3; bus.renderer_ry = 10'd3;
          bus.update_renable = 1'b1; bus.update_rx = 10'd3; bus.update_ry = 10'd3;
        end
        6: begin
          bus.vga_read = 1'b0;
          bus.update_renable = 1'b0;
          check("busy_rvalid", int'(bus.update_rvalid), 0);
          check_rgb("busy_colour", 0, 0, 0);
        end
        600: bus.clear_req = 1'b1;
        601: bus.clear_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    check("clear_busy_cycles", cnt, 1200);
    upd_read(3, 3, 2'd0);
    upd_read(0, 0, 2'd3);

    // Reset in the middle of a sweep restarts it.
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (600) @(negedge clk);
    check("mid_sweep_busy", int'(bus.busy), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_busy(cnt);
    check("reset_sweep_cycles", cnt, 1200);
    upd_read(0, 0, 2'd3);
    upd_read(20, 15, 2'd0);
    nb_read("noborder_again", 0, 0, 0);

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
